// File: rtl/proto_core_pkg.sv
// Shared core definitions: ALU opcode encodings, datapath widths and the issue bundle.
package proto_core_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 4;
    localparam int OPC_W     = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 4'b0000;
    localparam logic [OPC_W-1:0] OP_INC = 4'b0010;
    localparam logic [OPC_W-1:0] OP_DEC = 4'b0011;
    localparam logic [OPC_W-1:0] OP_ADD = 4'b0100;
    localparam logic [OPC_W-1:0] OP_SUB = 4'b0101;
    localparam logic [OPC_W-1:0] OP_OR  = 4'b1000;
    localparam logic [OPC_W-1:0] OP_AND = 4'b1001;
    localparam logic [OPC_W-1:0] OP_XOR = 4'b1010;
    localparam logic [OPC_W-1:0] OP_NOT = 4'b1011;

    typedef struct packed {
        logic [OPC_W-1:0]     opcode;
        logic [XLEN-1:0]      a;
        logic [XLEN-1:0]      b;
        logic [REG_IDX_W-1:0] rd;
    } issue_t;

endpackage

// File: rtl/regfile.sv
// Register file: two combinational read ports, one synchronous write port, r0 hardwired to zero.
module regfile
    import proto_core_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int XLEN  = proto_core_pkg::XLEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [REG_IDX_W-1:0] i_waddr,
    input  logic [XLEN-1:0]      i_wdata,
    input  logic [REG_IDX_W-1:0] i_raddr1,
    input  logic [REG_IDX_W-1:0] i_raddr2,
    output logic [XLEN-1:0]      o_rdata1,
    output logic [XLEN-1:0]      o_rdata2
);

    logic [XLEN-1:0] r_mem [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Reads see pre-edge contents; r0 is forced to zero regardless of the array.
    always_comb begin
        o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
        o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch/issue stage feeding the ALU: handshake, output register and optional writeback bypass.
// Define OPERAND_FETCH_BYPASS_EN to forward same-cycle writebacks and refresh stalled operands.
module operand_fetch
    import proto_core_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int XLEN  = proto_core_pkg::XLEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPC_W-1:0]     in_opcode,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [REG_IDX_W-1:0] in_rs1,
    input  logic [REG_IDX_W-1:0] in_rs2,
    input  logic [XLEN-1:0]      in_imm,
    input  logic                 in_use_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OPC_W-1:0]     out_opcode,
    output logic [XLEN-1:0]      out_a,
    output logic [XLEN-1:0]      out_b,
    output logic [REG_IDX_W-1:0] out_rd,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data
);

    logic            w_accept;
    logic            w_wb_live;
    logic [XLEN-1:0] w_rdata1;
    logic [XLEN-1:0] w_rdata2;
    logic [XLEN-1:0] w_a_cap;
    logic [XLEN-1:0] w_b_cap;

    logic            r_vld_p1;
    issue_t          r_iss_p1;

    regfile #(
        .NREGS (NREGS),
        .XLEN  (XLEN)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we     (wb_en),
        .i_waddr  (wb_rd),
        .i_wdata  (wb_data),
        .i_raddr1 (in_rs1),
        .i_raddr2 (in_rs2),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2)
    );

    assign in_ready  = !r_vld_p1 || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_wb_live = wb_en && (wb_rd != '0);

`ifdef OPERAND_FETCH_BYPASS_EN
    logic [REG_IDX_W-1:0] r_rs1_p1;
    logic [REG_IDX_W-1:0] r_rs2_p1;
    logic                 r_use_imm_p1;
    logic                 w_hit_a;
    logic                 w_hit_b;

    always_comb begin
        w_a_cap = w_rdata1;
        w_b_cap = in_use_imm ? in_imm : w_rdata2;
        if (w_wb_live && (wb_rd == in_rs1)) begin
            w_a_cap = wb_data;
        end
        if (w_wb_live && !in_use_imm && (wb_rd == in_rs2)) begin
            w_b_cap = wb_data;
        end
    end

    // Held-source matches for refreshing a stalled bundle.
    assign w_hit_a = w_wb_live && (wb_rd == r_rs1_p1);
    assign w_hit_b = w_wb_live && !r_use_imm_p1 && (wb_rd == r_rs2_p1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs1_p1     <= '0;
            r_rs2_p1     <= '0;
            r_use_imm_p1 <= 1'b0;
        end else if (!flush && w_accept) begin
            r_rs1_p1     <= in_rs1;
            r_rs2_p1     <= in_rs2;
            r_use_imm_p1 <= in_use_imm;
        end
    end
`else
    always_comb begin
        w_a_cap = w_rdata1;
        w_b_cap = in_use_imm ? in_imm : w_rdata2;
    end
`endif

    // Issue register stage: flush beats accept, accept beats drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_iss_p1 <= '0;
        end else if (flush) begin
            r_vld_p1 <= 1'b0;
        end else if (w_accept) begin
            r_vld_p1        <= 1'b1;
            r_iss_p1.opcode <= in_opcode;
            r_iss_p1.rd     <= in_rd;
            r_iss_p1.a      <= w_a_cap;
            r_iss_p1.b      <= w_b_cap;
        end else if (out_ready) begin
            r_vld_p1 <= 1'b0;
`ifdef OPERAND_FETCH_BYPASS_EN
        end else if (r_vld_p1) begin
            if (w_hit_a) begin
                r_iss_p1.a <= wb_data;
            end
            if (w_hit_b) begin
                r_iss_p1.b <= wb_data;
            end
`endif
        end
    end

    assign out_valid  = r_vld_p1;
    assign out_opcode = r_iss_p1.opcode;
    assign out_a      = r_iss_p1.a;
    assign out_b      = r_iss_p1.b;
    assign out_rd     = r_iss_p1.rd;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a scoreboard of expected issue bundles.
// Expectations follow OPERAND_FETCH_BYPASS_EN when it is defined for the build.
module tb_operand_fetch;

    typedef struct {
        logic [3:0]  opcode;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic        use_imm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [3:0]  in_rd;
    logic [3:0]  in_rs1;
    logic [3:0]  in_rs2;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_rd;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_rf [16];
    logic        m_vld;
    exp_t        q [$];

    operand_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_rd     (out_rd),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = 32'h0;
        m_vld = 1'b0;
        q.delete();
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [3:0] rd, input logic use_imm, input logic [31:0] imm);
        in_valid   = 1'b1;
        in_opcode  = op;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rd      = rd;
        in_use_imm = use_imm;
        in_imm     = imm;
    endtask

    // One clock: check current outputs against the scoreboard, predict the edge, then advance.
    task automatic tick();
        logic m_ready;
        logic acc;
        logic wb_live;
        exp_t e;
        #1;
        m_ready = !m_vld || out_ready;
        wb_live = wb_en && (wb_rd != 4'd0);
        check("in_ready", {31'b0, in_ready}, {31'b0, m_ready});
        check("out_valid", {31'b0, out_valid}, {31'b0, m_vld});
        if (m_vld) begin
            if (q.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                check("out_opcode", {28'b0, out_opcode}, {28'b0, q[0].opcode});
                check("out_a", out_a, q[0].a);
                check("out_b", out_b, q[0].b);
                check("out_rd", {28'b0, out_rd}, {28'b0, q[0].rd});
                if (out_ready || flush) void'(q.pop_front());
            end
        end
        acc = in_valid && m_ready && !flush;
        e.opcode  = in_opcode;
        e.rd      = in_rd;
        e.rs1     = in_rs1;
        e.rs2     = in_rs2;
        e.use_imm = in_use_imm;
        e.a       = m_rf[in_rs1];
        e.b       = in_use_imm ? in_imm : m_rf[in_rs2];
`ifdef OPERAND_FETCH_BYPASS_EN
        if (wb_live && wb_rd == in_rs1) e.a = wb_data;
        if (wb_live && !in_use_imm && wb_rd == in_rs2) e.b = wb_data;
        if (m_vld && !out_ready && !flush && q.size() > 0) begin
            if (wb_live && wb_rd == q[0].rs1) q[0].a = wb_data;
            if (wb_live && !q[0].use_imm && wb_rd == q[0].rs2) q[0].b = wb_data;
        end
`endif
        if (acc) q.push_back(e);
        m_vld = flush ? 1'b0 : (acc ? 1'b1 : (out_ready ? 1'b0 : m_vld));
        if (wb_live) m_rf[wb_rd] = wb_data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_opcode = 4'h0; in_rd = 4'h0;
        in_rs1 = 4'h0; in_rs2 = 4'h0; in_imm = 32'h0; in_use_imm = 1'b0;
        out_ready = 1'b1; wb_en = 1'b0; wb_rd = 4'h0; wb_data = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_a", out_a, 32'h0);
        check("rst_out_b", out_b, 32'h0);
        check("rst_out_opcode", {28'b0, out_opcode}, 32'd0);
        check("rst_out_rd", {28'b0, out_rd}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;

        // Load R3 and R4, then issue ADD r5 = r3 + r4.
        wb_en = 1'b1; wb_rd = 4'd3; wb_data = 32'h10; tick();
        wb_rd = 4'd4; wb_data = 32'h05; tick();
        wb_en = 1'b0;
        issue(4'b0100, 4'd3, 4'd4, 4'd5, 1'b0, 32'h0); tick();
        in_valid = 1'b0;
        check("add_valid", {31'b0, out_valid}, 32'd1);
        check("add_a", out_a, 32'h10);
        check("add_b", out_b, 32'h05);
        check("add_opcode", {28'b0, out_opcode}, 32'h4);
        check("add_rd", {28'b0, out_rd}, 32'd5);
        tick();

        // Immediate operand and NOP pass-through.
        issue(4'b0101, 4'd3, 4'd4, 4'd6, 1'b1, 32'hFFFF_FFFF); tick();
        check("imm_b", out_b, 32'hFFFF_FFFF);
        issue(4'b0000, 4'd4, 4'd3, 4'd1, 1'b0, 32'h0); tick();
        check("nop_valid", {31'b0, out_valid}, 32'd1);

        // Write to r0 is ignored; r0 still reads zero.
        wb_en = 1'b1; wb_rd = 4'd0; wb_data = 32'hDEAD_BEEF;
        issue(4'b1000, 4'd0, 4'd0, 4'd7, 1'b0, 32'h0); tick();
        wb_en = 1'b0;
        issue(4'b1001, 4'd0, 4'd3, 4'd7, 1'b0, 32'h0); tick();
        check("r0_a", out_a, 32'h0);
        in_valid = 1'b0; tick();

        // Backpressure for three cycles, then release into back-to-back issue.
        issue(4'b0100, 4'd3, 4'd4, 4'd8, 1'b0, 32'h0); tick();
        out_ready = 1'b0;
        issue(4'b1010, 4'd4, 4'd3, 4'd9, 1'b0, 32'h0);
        repeat (3) tick();
        check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        check("stall_rd", {28'b0, out_rd}, 32'd8);
        out_ready = 1'b1; tick();
        check("release_rd", {28'b0, out_rd}, 32'd9);
        for (int i = 0; i < 4; i++) begin
            issue(4'b0010, 4'(i + 1), 4'd4, 4'(10 + i), 1'b0, 32'h0);
            tick();
        end
        check("b2b_rd", {28'b0, out_rd}, 32'd13);
        in_valid = 1'b0; tick();

        // Same-cycle writeback to rs1 during accept.
        wb_en = 1'b1; wb_rd = 4'd3; wb_data = 32'h77;
        issue(4'b0100, 4'd3, 4'd4, 4'd10, 1'b0, 32'h0); tick();
        wb_en = 1'b0; in_valid = 1'b0;
`ifdef OPERAND_FETCH_BYPASS_EN
        check("hazard_a", out_a, 32'h77);
`else
        check("hazard_a", out_a, 32'h10);
`endif
        tick();

        // Writeback to a held rs2 while stalled.
        issue(4'b0100, 4'd3, 4'd4, 4'd11, 1'b0, 32'h0); tick();
        in_valid = 1'b0; out_ready = 1'b0; tick();
        wb_en = 1'b1; wb_rd = 4'd4; wb_data = 32'h99; tick();
        wb_en = 1'b0;
`ifdef OPERAND_FETCH_BYPASS_EN
        check("refresh_b", out_b, 32'h99);
`else
        check("refresh_b", out_b, 32'h05);
`endif
        tick();
        out_ready = 1'b1; tick();

        // Flush together with accept drops the instruction.
        issue(4'b1011, 4'd3, 4'd4, 4'd12, 1'b0, 32'h0); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        tick();

        // Asynchronous reset while stalled.
        issue(4'b0100, 4'd3, 4'd4, 4'd13, 1'b0, 32'h0); tick();
        in_valid = 1'b0; out_ready = 1'b0; tick();
        #3 rst = 1'b1;
        #1;
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_a", out_a, 32'h0);
        check("arst_b", out_b, 32'h0);
        check("arst_opcode", {28'b0, out_opcode}, 32'd0);
        check("arst_rd", {28'b0, out_rd}, 32'd0);
        check("arst_in_ready", {31'b0, in_ready}, 32'd1);
        model_reset();
        #1 rst = 1'b0;
        out_ready = 1'b1;

        // Register file was cleared: R3 reads zero, new write is visible.
        wb_en = 1'b1; wb_rd = 4'd5; wb_data = 32'h1234; tick();
        wb_en = 1'b0;
        issue(4'b0100, 4'd5, 4'd3, 4'd14, 1'b0, 32'h0); tick();
        in_valid = 1'b0;
        check("post_rst_a", out_a, 32'h1234);
        check("post_rst_b", out_b, 32'h0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
